// File: rtl/mpeg_bs_pkg.sv
// Shared definitions for the MPEG bitstream window: default geometry and FSM state codes.
package mpeg_bs_pkg;

    localparam int WIN_BITS_DEF = 32;
    localparam int LANES_DEF    = 4;

    localparam logic [1:0] ST_FILL  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/bitwin_align.sv
// Combinational shift/merge for the bitstream accumulator: discard n leading bits,
// then append a beat directly below the bits that remain.
module bitwin_align
    import mpeg_bs_pkg::*;
#(
    parameter int  WIN_BITS = WIN_BITS_DEF,
    parameter int  LANES    = LANES_DEF,
    localparam int ACC_BITS = WIN_BITS + 8 * LANES,
    localparam int NW       = $clog2(WIN_BITS + 1),
    localparam int CW       = NW + 4
) (
    input  logic [ACC_BITS-1:0] acc,
    input  logic [CW-1:0]       incnt,
    input  logic [NW-1:0]       n,
    input  logic                beat_en,
    input  logic [8*LANES-1:0]  beat,
    output logic [ACC_BITS-1:0] acc_next,
    output logic [CW-1:0]       incnt_next,
    output logic                underflow
);

    logic [CW-1:0]       n_ext;
    logic [CW-1:0]       kept;
    logic [ACC_BITS-1:0] shifted;
    logic [ACC_BITS-1:0] beat_wide;

    assign n_ext = CW'(n);

    // NOTE: every signal written here gets a value on every path, otherwise a latch is inferred.
    always_comb begin
        underflow = (n_ext > incnt);
        kept      = underflow ? '0 : incnt - n_ext;
        shifted   = underflow ? '0 : acc << n;
        beat_wide = '0;
        // Shifting the beat right from the top lands its first bit just below the kept bits.
        if (beat_en) begin
            beat_wide = {beat, {WIN_BITS{1'b0}}} >> kept;
        end
        acc_next   = shifted | beat_wide;
        incnt_next = kept + (beat_en ? CW'(8 * LANES) : '0);
    end

endmodule

// File: rtl/bitstream_window.sv
// Bitstream window: buffers byte beats in a left-aligned accumulator and presents the
// next WIN_BITS bits to a decoder, which consumes them with variable-length flushes.
module bitstream_window
    import mpeg_bs_pkg::*;
#(
    parameter int  WIN_BITS = WIN_BITS_DEF,
    parameter int  LANES    = LANES_DEF,
    localparam int ACC_BITS = WIN_BITS + 8 * LANES,
    localparam int NW       = $clog2(WIN_BITS + 1),
    localparam int CW       = NW + 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [8*LANES-1:0]  in_data,
    input  logic                in_last,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [NW-1:0]       req_n,
    output logic [WIN_BITS-1:0] win_data,
    output logic                win_valid,
    output logic [CW-1:0]       incnt,
    output logic                done,
    output logic                err
);

    logic [1:0]          state;
    logic [1:0]          state_next;
    logic [ACC_BITS-1:0] acc;
    logic [ACC_BITS-1:0] acc_next;
    logic [CW-1:0]       incnt_next;
    logic                beat_acc;
    logic                req_acc;
    logic                underflow;
    logic [NW-1:0]       flush_n;

    // Handshake readiness depends only on registered state, never on req_*.
    assign in_ready  = (incnt <= CW'(WIN_BITS)) && (state == ST_FILL || state == ST_RUN);
    assign win_valid = (state == ST_RUN) || (state == ST_DRAIN);
    assign req_ready = win_valid;
    assign done      = (state == ST_DONE);
    assign win_data  = acc[ACC_BITS-1 -: WIN_BITS];

    assign beat_acc = in_valid && in_ready;
    assign req_acc  = req_valid && req_ready;
    assign flush_n  = req_acc ? req_n : '0;

    bitwin_align #(
        .WIN_BITS (WIN_BITS),
        .LANES    (LANES)
    ) u_align (
        .acc        (acc),
        .incnt      (incnt),
        .n          (flush_n),
        .beat_en    (beat_acc),
        .beat       (in_data),
        .acc_next   (acc_next),
        .incnt_next (incnt_next),
        .underflow  (underflow)
    );

    always_comb begin
        state_next = state;
        case (state)
            ST_FILL, ST_RUN: begin
                if (beat_acc && in_last) begin
                    state_next = ST_DRAIN;
                end else if (beat_acc || req_acc) begin
                    state_next = (incnt_next >= CW'(WIN_BITS)) ? ST_RUN : ST_FILL;
                end
            end
            ST_DRAIN: begin
                if (req_acc && incnt_next == '0) begin
                    state_next = ST_DONE;
                end
            end
            default: state_next = ST_DONE;
        endcase
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_FILL;
            acc   <= '0;
            incnt <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
            incnt <= incnt_next;
            if (req_acc && underflow) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bitstream_window.sv
// Self-checking bench for bitstream_window: directed scenarios plus randomized streams,
// compared every cycle against a bit-queue model of the stream.
module tb_bitstream_window;

    localparam int WIN_BITS = 32;
    localparam int LANES    = 4;
    localparam int BEAT     = 8 * LANES;
    localparam int NW       = $clog2(WIN_BITS + 1);
    localparam int CW       = NW + 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [BEAT-1:0]     in_data;
    logic                in_last;
    logic                req_valid;
    logic                req_ready;
    logic [NW-1:0]       req_n;
    logic [WIN_BITS-1:0] win_data;
    logic                win_valid;
    logic [CW-1:0]       incnt;
    logic                done;
    logic                err;

    int n_checks = 0;
    int n_errors = 0;

    // Model: the buffered stream as a queue of bits, oldest first.
    bit m_q[$];
    bit m_last;
    bit m_err;

    always #5 clk = ~clk;

    bitstream_window #(
        .WIN_BITS (WIN_BITS),
        .LANES    (LANES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_n     (req_n),
        .win_data  (win_data),
        .win_valid (win_valid),
        .incnt     (incnt),
        .done      (done),
        .err       (err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [WIN_BITS-1:0] m_window();
        logic [WIN_BITS-1:0] w = '0;
        for (int i = 0; i < WIN_BITS && i < m_q.size(); i++) begin
            w[WIN_BITS-1-i] = m_q[i];
        end
        return w;
    endfunction

    function automatic bit m_in_ready();
        return !m_last && (m_q.size() <= WIN_BITS);
    endfunction

    function automatic bit m_win_valid();
        return m_last ? (m_q.size() > 0) : (m_q.size() >= WIN_BITS);
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".win"},   win_data,  m_window());
        check({tag, ".cnt"},   incnt,     m_q.size());
        check({tag, ".wval"},  win_valid, m_win_valid());
        check({tag, ".rrdy"},  req_ready, m_win_valid());
        check({tag, ".irdy"},  in_ready,  m_in_ready());
        check({tag, ".done"},  done,      m_last && m_q.size() == 0);
        check({tag, ".err"},   err,       m_err);
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, leave outputs settled.
    task automatic cycle(input bit r, input bit iv, input logic [BEAT-1:0] d, input bit il,
                         input bit rv, input int rn);
        bit beat_ok;
        bit req_ok;
        rst       = r;
        in_valid  = iv;
        in_data   = d;
        in_last   = il;
        req_valid = rv;
        req_n     = NW'(rn);
        beat_ok   = iv && m_in_ready();
        req_ok    = rv && m_win_valid();
        @(posedge clk);
        #1;
        if (r) begin
            m_q.delete();
            m_last = 0;
            m_err  = 0;
        end else begin
            if (req_ok) begin
                if (rn > m_q.size()) begin
                    m_err = 1;
                    m_q.delete();
                end else begin
                    for (int i = 0; i < rn; i++) void'(m_q.pop_front());
                end
            end
            if (beat_ok) begin
                for (int i = BEAT - 1; i >= 0; i--) m_q.push_back(d[i]);
                if (il) m_last = 1;
            end
        end
        rst       = 0;
        in_valid  = 0;
        in_last   = 0;
        req_valid = 0;
    endtask

    initial begin
        bit              iv, il, rv, r;
        int              rn, hi;
        logic [BEAT-1:0] d;

        rst = 1; in_valid = 0; in_data = '0; in_last = 0; req_valid = 0; req_n = '0;
        m_last = 0; m_err = 0;

        // Reset state
        cycle(1, 0, '0, 0, 0, 0);
        cycle(1, 0, '0, 0, 0, 0);
        check_all("rst");
        check("rst.cnt0", incnt, 0);
        check("rst.irdy1", in_ready, 1);
        check("rst.rrdy0", req_ready, 0);

        // First beat fills the window exactly
        cycle(0, 1, 32'h000001B3, 0, 0, 0);
        check_all("first");
        check("first.win", win_data, 32'h000001B3);
        check("first.cnt", incnt, 32);
        check("first.wval", win_valid, 1);

        // Second beat accepted at incnt == WIN_BITS, then flush 8
        cycle(0, 1, 32'h12345678, 0, 0, 0);
        check_all("second");
        check("second.irdy0", in_ready, 0);
        cycle(0, 0, '0, 0, 1, 8);
        check_all("flush8");
        check("flush8.win", win_data, 32'h0001B312);
        check("flush8.cnt", incnt, 56);

        // At incnt=40 a beat is refused while a flush still proceeds
        cycle(0, 0, '0, 0, 1, 16);
        check("at40.cnt", incnt, 40);
        check("at40.irdy0", in_ready, 0);
        cycle(0, 1, 32'hDEADBEEF, 0, 1, 12);
        check_all("refuse");
        check("refuse.win", win_data, 32'h23456780);
        check("refuse.cnt", incnt, 28);
        check("refuse.wval0", win_valid, 0);

        // A beat is only accepted at incnt <= WIN_BITS, so the merge case runs at incnt=32
        cycle(1, 0, '0, 0, 0, 0);
        cycle(0, 1, 32'h000001B3, 0, 0, 0);
        cycle(0, 1, 32'hAABBCCDD, 0, 1, 12);
        check_all("merge");
        check("merge.win", win_data, 32'h001B3AAB);
        check("merge.cnt", incnt, 52);

        // Last beat, drain with two flushes to DONE
        cycle(1, 0, '0, 0, 0, 0);
        cycle(0, 1, 32'hFFFFFFFF, 1, 0, 0);
        check_all("drain");
        check("drain.irdy0", in_ready, 0);
        check("drain.wval1", win_valid, 1);
        cycle(0, 0, '0, 0, 1, 16);
        check("drain16.win", win_data, 32'hFFFF0000);
        check("drain16.cnt", incnt, 16);
        cycle(0, 0, '0, 0, 1, 16);
        check_all("done");
        check("done.done", done, 1);
        check("done.irdy0", in_ready, 0);
        cycle(0, 1, 32'h11111111, 0, 1, 4);
        check_all("done_hold");
        check("done_hold.cnt", incnt, 0);

        // Underflow in DRAIN
        cycle(1, 0, '0, 0, 0, 0);
        cycle(0, 1, 32'h0F0F0F0F, 1, 0, 0);
        cycle(0, 0, '0, 0, 1, 27);
        check("uf_pre.cnt", incnt, 5);
        check("uf_pre.win", win_data, 32'h78000000);
        cycle(0, 0, '0, 0, 1, 8);
        check_all("uf");
        check("uf.err", err, 1);
        check("uf.cnt", incnt, 0);
        check("uf.done", done, 1);

        // Reset during a flush at incnt=48
        cycle(1, 0, '0, 0, 0, 0);
        check("rst_err.err", err, 0);
        cycle(0, 1, 32'hCAFEF00D, 0, 0, 0);
        cycle(0, 1, 32'h01234567, 0, 0, 0);
        cycle(0, 0, '0, 0, 1, 16);
        check("pre_rst.cnt", incnt, 48);
        cycle(1, 1, 32'h55555555, 0, 1, 8);
        check_all("midrst");
        check("midrst.cnt", incnt, 0);
        check("midrst.wval0", win_valid, 0);
        check("midrst.irdy1", in_ready, 1);
        check("midrst.err", err, 0);

        // Randomized streams
        for (int s = 0; s < 10; s++) begin
            cycle(1, 0, '0, 0, 0, 0);
            check_all("rnd_rst");
            for (int c = 0; c < 90; c++) begin
                r  = ($urandom_range(0, 149) == 0);
                iv = ($urandom_range(0, 3) != 0);
                il = (c > 25) && ($urandom_range(0, 9) == 0);
                rv = ($urandom_range(0, 2) != 0);
                d  = $urandom;
                hi = m_last ? m_q.size() + 3 : WIN_BITS;
                if (hi > WIN_BITS) hi = WIN_BITS;
                rn = $urandom_range(0, hi);
                cycle(r, iv, d, il, rv, rn);
                check_all("rnd");
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
